serial_subtr: RTL and testbench

- Parametrised, digit-serial two's-complement subtractor computing a - b over WIDTH bits, DIGIT bits per clock.
- Uses a start/busy/done handshake.
- Reports unsigned borrow, signed overflow and a zero flag, with optional saturation.
- Replaces single-cycle fixed-width subtractors in datapaths where area matters more than latency.

---
 rtl/serial_subtr_pkg.sv | 36 +++
 rtl/serial_subtr_sub_digit.sv | 19 +
 rtl/serial_subtr.sv | 174 +++++++++++++++++
 tb/tb_serial_subtr.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtr_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// Holds the FSM state encoding and the saturation clamp generator.
package serial_subtr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int MAX_WIDTH = 64;

   // Clamp value for a given width: signed gives most-negative/most-positive,
   // unsigned gives zero on underflow (neg) or all-ones otherwise.
   function automatic logic [MAX_WIDTH-1:0] sat_limit(input int width,
                                                      input logic is_signed,
                                                      input logic neg);
      logic [MAX_WIDTH-1:0] lim;
      lim = '0;
      if (is_signed) begin
         if (neg) begin
            lim = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
         end else begin
            lim = ~({MAX_WIDTH{1'b1}} << (width - 1));
         end
      end else begin
         if (neg) begin
            lim = '0;
         end else begin
            lim = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
         end
      end
      return lim;
   endfunction

endpackage

// File: rtl/serial_subtr_sub_digit.sv
// One DIGIT-bit slice of a ripple-borrow subtractor (purely combinational).
module sub_digit #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] x_i,
   input  logic [DIGIT-1:0] y_i,
   input  logic             bin_i,
   output logic [DIGIT-1:0] d_o,
   output logic             bout_o
);

   logic [DIGIT:0] full_s;

   // Extra top bit goes to 1 exactly when x - y - bin is negative.
   assign full_s = {1'b0, x_i} - {1'b0, y_i} - {{DIGIT{1'b0}}, bin_i};
   assign d_o    = full_s[DIGIT-1:0];
   assign bout_o = full_s[DIGIT];

endmodule

// File: rtl/serial_subtr.sv
// Digit-serial two's-complement subtractor a - b, DIGIT bits per clock,
// with start/busy/done handshake, borrow/overflow/zero flags and optional saturation.
module serial_subtr
   import serial_subtr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             is_signed_i,
   input  logic             sat_en_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d;
   logic             bin_q, bin_d, signed_q, signed_d, sat_q, sat_d;
   logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;

   logic [DIGIT-1:0]     dig_s;
   logic                 bout_s;
   logic [WIDTH-1:0]     raw_s, lim_s, sat_diff_s;
   logic [MAX_WIDTH-1:0] lim_full_s;
   logic                 ovf_s;

   sub_digit #(.DIGIT(DIGIT)) u_digit (
      .x_i    (a_sh_q[DIGIT-1:0]),
      .y_i    (b_sh_q[DIGIT-1:0]),
      .bin_i  (bin_q),
      .d_o    (dig_s),
      .bout_o (bout_s)
   );

   // Result as it will look after this cycle's digit; on the last RUN cycle it is the full raw difference.
   always_comb begin
      raw_s = res_q >> DIGIT;
      raw_s[WIDTH-1 -: DIGIT] = dig_s;
      ovf_s = (a_msb_q != b_msb_q) && (raw_s[WIDTH-1] != a_msb_q);
      lim_full_s = sat_limit(WIDTH, signed_q, signed_q ? a_msb_q : bout_s);
      lim_s = lim_full_s[WIDTH-1:0];
      if (!sat_q) begin
         sat_diff_s = raw_s;
      end else if (signed_q) begin
         sat_diff_s = ovf_s ? lim_s : raw_s;
      end else begin
         sat_diff_s = bout_s ? lim_s : raw_s;
      end
   end

   // Next-state, datapath and held-result logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      bin_d    = bin_q;
      signed_d = signed_q;
      sat_d    = sat_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               a_sh_d   = a_i;
               b_sh_d   = b_i;
               a_msb_d  = a_i[WIDTH-1];
               b_msb_d  = b_i[WIDTH-1];
               signed_d = is_signed_i;
               sat_d    = sat_en_i;
               res_d    = '0;
               cnt_d    = '0;
               bin_d    = 1'b0;
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> DIGIT;
            b_sh_d = b_sh_q >> DIGIT;
            res_d  = raw_s;
            bin_d  = bout_s;
            cnt_d  = cnt_q + CW'(1);
            // Held outputs only move on the edge that enters DONE.
            if (cnt_q == CNT_LAST) begin
               diff_d   = sat_diff_s;
               borrow_d = bout_s;
               ovf_d    = ovf_s;
               zero_d   = (sat_diff_s == '0);
               state_d  = DONE;
            end else begin
               state_d  = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         bin_q    <= 1'b0;
         signed_q <= 1'b0;
         sat_q    <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         bin_q    <= bin_d;
         signed_q <= signed_d;
         sat_q    <= sat_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign diff_o   = diff_q;
   assign borrow_o = borrow_q;
   assign ovf_o    = ovf_q;
   assign zero_o   = zero_q;

endmodule

// File: tb/tb_serial_subtr.sv
// Scoreboard bench for serial_subtr: three instances (DIGIT=2, 1, 8) share operands;
// expected results are queued at issue time and popped by a monitor on each done pulse.
module tb_serial_subtr;

   typedef struct {
      logic [7:0] diff;
      logic       borrow;
      logic       ovf;
      logic       zero;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start0, start1, start2;
   logic [7:0] a, b;
   logic       sgn, sat;
   logic       busy0, busy1, busy2, done0, done1, done2;
   logic [7:0] diff0, diff1, diff2;
   logic       bor0, bor1, bor2, ovf0, ovf1, ovf2, zero0, zero1, zero2;

   exp_t q0[$], q1[$], q2[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   bc0 = 0, bc1 = 0, bc2 = 0;
   int   nlat[3] = '{4, 8, 1};

   serial_subtr #(.WIDTH(8), .DIGIT(2)) dut0 (
      .clk_i(clk), .rst_i(rst), .start_i(start0), .a_i(a), .b_i(b),
      .is_signed_i(sgn), .sat_en_i(sat), .busy_o(busy0), .done_o(done0),
      .diff_o(diff0), .borrow_o(bor0), .ovf_o(ovf0), .zero_o(zero0));

   serial_subtr #(.WIDTH(8), .DIGIT(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(a), .b_i(b),
      .is_signed_i(sgn), .sat_en_i(sat), .busy_o(busy1), .done_o(done1),
      .diff_o(diff1), .borrow_o(bor1), .ovf_o(ovf1), .zero_o(zero1));

   serial_subtr #(.WIDTH(8), .DIGIT(8)) dut2 (
      .clk_i(clk), .rst_i(rst), .start_i(start2), .a_i(a), .b_i(b),
      .is_signed_i(sgn), .sat_en_i(sat), .busy_o(busy2), .done_o(done2),
      .diff_o(diff2), .borrow_o(bor2), .ovf_o(ovf2), .zero_o(zero2));

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   function automatic logic active(input int u);
      case (u)
         0: return busy0 | done0;
         1: return busy1 | done1;
         default: return busy2 | done2;
      endcase
   endfunction

   function automatic int qsize(input int u);
      case (u)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic check_done(input int u, input logic [7:0] d, input logic br, input logic ov,
                             input logic z, input int bc);
      exp_t e;
      if (qsize(u) == 0) begin
         n_checks++;
         $display("FAIL unexpected_done unit %0d: got a done pulse, expected none (cycle %0d)", u, cyc);
         return;
      end
      case (u)
         0: e = q0.pop_front();
         1: e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
      chk($sformatf("u%0d_diff", u), 32'(d), 32'(e.diff));
      chk($sformatf("u%0d_borrow", u), 32'(br), 32'(e.borrow));
      chk($sformatf("u%0d_ovf", u), 32'(ov), 32'(e.ovf));
      chk($sformatf("u%0d_zero", u), 32'(z), 32'(e.zero));
      chk($sformatf("u%0d_latency", u), 32'(cyc), 32'(e.cyc));
      chk($sformatf("u%0d_busy_cycles", u), 32'(bc), 32'(nlat[u]));
   endtask

   // Monitor: counts busy cycles and checks every done pulse against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         bc0 = 0; bc1 = 0; bc2 = 0;
      end else begin
         if (busy0) bc0++;
         if (busy1) bc1++;
         if (busy2) bc2++;
         if (done0) begin check_done(0, diff0, bor0, ovf0, zero0, bc0); bc0 = 0; end
         if (done1) begin check_done(1, diff1, bor1, ovf1, zero1, bc1); bc1 = 0; end
         if (done2) begin check_done(2, diff2, bor2, ovf2, zero2, bc2); bc2 = 0; end
      end
   end

   task automatic wait_idle(input int u);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!active(u)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL idle_timeout unit %0d: still busy, expected idle (cycle %0d)", u, cyc);
      end
   endtask

   task automatic issue(input int u, input logic [7:0] av, input logic [7:0] bv, input logic s,
                        input logic st, input logic [7:0] ed, input logic eb, input logic eo,
                        input logic ez);
      exp_t e;
      wait_idle(u);
      a = av; b = bv; sgn = s; sat = st;
      case (u)
         0: start0 = 1'b1;
         1: start1 = 1'b1;
         default: start2 = 1'b1;
      endcase
      @(posedge clk);
      #1;
      e.diff = ed; e.borrow = eb; e.ovf = eo; e.zero = ez; e.cyc = cyc + nlat[u];
      case (u)
         0: begin q0.push_back(e); start0 = 1'b0; end
         1: begin q1.push_back(e); start1 = 1'b0; end
         default: begin q2.push_back(e); start2 = 1'b0; end
      endcase
      a = 8'hAA; b = 8'h55; sgn = ~s; sat = ~st;
   endtask

   initial begin
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      a = 8'h00; b = 8'h00; sgn = 1'b0; sat = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_diff", 32'(diff0), 32'd0);
      chk("rst_flags", 32'({bor0, ovf0, zero0}), 32'd0);
      rst = 1'b0;

      issue(0, 8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
      issue(0, 8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
      issue(0, 8'h03, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      issue(0, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
      issue(0, 8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
      issue(0, 8'h7F, 8'hFF, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
      issue(0, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      issue(0, 8'h90, 8'h10, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);

      // A second start during RUN must be dropped.
      issue(0, 8'h20, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      a = 8'hFF; b = 8'h00; start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      // Accepted in the cycle right after done.
      issue(0, 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

      // Reset after two RUN cycles abandons the operation.
      issue(0, 8'h33, 8'h11, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      q0.delete();
      chk("midrst_busy", 32'(busy0), 32'd0);
      chk("midrst_done", 32'(done0), 32'd0);
      chk("midrst_diff", 32'(diff0), 32'd0);
      chk("midrst_flags", 32'({bor0, ovf0, zero0}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      issue(0, 8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

      issue(1, 8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
      issue(2, 8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
      issue(2, 8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
      issue(1, 8'h03, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      end
      repeat (4) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
